// File: rtl/pc_gen_if.sv
// Fetch-request bundle between the PC generator and its core/instruction-memory side.
interface pc_gen_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   pc_gen_stall_in;
    logic                   pc_gen_compressed_in;
    logic                   pc_gen_redirect_valid_in;
    logic [DATA_WIDTH-1:0]  pc_gen_redirect_target_in;
    logic                   pc_gen_trap_valid_in;
    logic [DATA_WIDTH-1:0]  pc_gen_trap_vector_in;
    logic                   pc_gen_req_ready_in;
    logic                   pc_gen_req_valid_out;
    logic [DATA_WIDTH-1:0]  pc_gen_pc_out;
    logic [DATA_WIDTH-1:0]  pc_gen_next_pc_out;
    logic                   pc_gen_misaligned_out;
    logic [COUNT_WIDTH-1:0] pc_gen_fetch_count_out;

    modport master (
        output pc_gen_stall_in, pc_gen_compressed_in, pc_gen_redirect_valid_in,
               pc_gen_redirect_target_in, pc_gen_trap_valid_in, pc_gen_trap_vector_in,
               pc_gen_req_ready_in,
        input  pc_gen_req_valid_out, pc_gen_pc_out, pc_gen_next_pc_out,
               pc_gen_misaligned_out, pc_gen_fetch_count_out
    );

    modport slave (
        input  pc_gen_stall_in, pc_gen_compressed_in, pc_gen_redirect_valid_in,
               pc_gen_redirect_target_in, pc_gen_trap_valid_in, pc_gen_trap_vector_in,
               pc_gen_req_ready_in,
        output pc_gen_req_valid_out, pc_gen_pc_out, pc_gen_next_pc_out,
               pc_gen_misaligned_out, pc_gen_fetch_count_out
    );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program counter: valid/ready fetch request, +2/+4 stepping,
// redirect/trap handling with misalignment halt, and an accepted-fetch counter.
module pc_gen #(
    parameter int                  DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter bit                  COMPRESSED_EN = 1'b1,
    parameter int                  COUNT_WIDTH   = 16
) (
    input  logic   clk_in,
    input  logic   rst_in,
    pc_gen_if.slave bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK =
        COMPRESSED_EN ? DATA_WIDTH'(1) : DATA_WIDTH'(3);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  pc;
    logic [DATA_WIDTH-1:0]  next_pc;
    logic [COUNT_WIDTH-1:0] count;
    logic                   misaligned;
    logic                   valid;
    logic                   accept;
    logic                   target_bad;

    assign next_pc    = pc + ((COMPRESSED_EN && bus.pc_gen_compressed_in) ?
                              DATA_WIDTH'(2) : DATA_WIDTH'(4));
    assign valid      = (state == FETCH) && !bus.pc_gen_stall_in;
    assign accept     = valid && bus.pc_gen_req_ready_in;
    assign target_bad = |(bus.pc_gen_redirect_target_in & ALIGN_MASK);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            count      <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            // Counted even when a redirect/trap replaces the advance below.
            if (accept)
                count <= count + COUNT_WIDTH'(1);

            if (bus.pc_gen_trap_valid_in) begin
                pc    <= bus.pc_gen_trap_vector_in & ~ALIGN_MASK;
                state <= FETCH;
            end else if (bus.pc_gen_redirect_valid_in && state != HALT) begin
                if (target_bad) begin
                    misaligned <= 1'b1;
                    state      <= HALT;
                end else begin
                    pc    <= bus.pc_gen_redirect_target_in;
                    state <= FETCH;
                end
            end else begin
                if (state == BOOT)
                    state <= FETCH;
                if (accept)
                    pc <= next_pc;
            end
        end
    end

    assign bus.pc_gen_req_valid_out   = valid;
    assign bus.pc_gen_pc_out          = pc;
    assign bus.pc_gen_next_pc_out     = next_pc;
    assign bus.pc_gen_misaligned_out  = misaligned;
    assign bus.pc_gen_fetch_count_out = count;
endmodule
